tracking_arbiter: RTL and testbench

TRACKING_ARBITER -- requirements
Module: tracking_arbiter

---
 rtl/tracking_arbiter_if.sv | 26 ++
 rtl/tracking_arbiter.sv | 113 +++++++++++
 tb/tb_tracking_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tracking_arbiter_if.sv
// Handshake bundle between the tracking arbiter, its requesting channels and
// the shared tracking loops.
interface tracking_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_WIDTH    = 2
);
  logic [NUM_CHANNELS-1:0] req_valid;
  logic                    loops_ready;
  logic                    loops_start;
  logic [SEL_WIDTH-1:0]    loops_sel;
  logic [NUM_CHANNELS-1:0] chan_ready;
  logic                    busy;
  logic [NUM_CHANNELS-1:0] pending;
  logic                    overrun;
  logic                    timeout_err;

  modport master (
    input  req_valid, loops_ready,
    output loops_start, loops_sel, chan_ready, busy, pending, overrun, timeout_err
  );

  modport slave (
    output req_valid, loops_ready,
    input  loops_start, loops_sel, chan_ready, busy, pending, overrun, timeout_err
  );
endinterface

// File: rtl/tracking_arbiter.sv
// Round-robin arbiter time-sharing one tracking_loops instance among several
// channels; every output is registered.
module tracking_arbiter #(
  parameter int NUM_CHANNELS   = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               global_reset,
  tracking_arbiter_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                  state_reg;
  logic [NUM_CHANNELS-1:0] pending_reg;
  logic [NUM_CHANNELS-1:0] chan_ready_reg;
  logic [SEL_WIDTH-1:0]    sel_reg;
  logic [SEL_WIDTH-1:0]    last_grant_reg;
  logic [TW-1:0]           timer_reg;
  logic                    start_reg;
  logic                    busy_reg;
  logic                    overrun_reg;
  logic                    timeout_reg;

  logic [NUM_CHANNELS-1:0] sel_hit;
  logic [NUM_CHANNELS-1:0] dup_req;
  logic                    grant_found;
  logic [SEL_WIDTH-1:0]    grant_idx;

  // A request landing on the channel being started re-queues it instead of
  // counting as an overrun: the set wins over the START clear.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    assign sel_hit[gi] = (state_reg == START) && (sel_reg == SEL_WIDTH'(gi));
    assign dup_req[gi] = bus.req_valid[gi] && pending_reg[gi] && !sel_hit[gi];
  end

  // Walk from the farthest candidate back to last_grant+1 so the nearest
  // pending channel is the last one written.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      if (pending_reg[(int'(last_grant_reg) + k) % NUM_CHANNELS]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_WIDTH'((int'(last_grant_reg) + k) % NUM_CHANNELS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      chan_ready_reg <= '0;
      sel_reg        <= '0;
      last_grant_reg <= SEL_WIDTH'(NUM_CHANNELS - 1);
      timer_reg      <= '0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      pending_reg    <= (pending_reg & ~sel_hit) | bus.req_valid;
      start_reg      <= 1'b0;
      chan_ready_reg <= '0;
      if (|dup_req) overrun_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            sel_reg   <= grant_idx;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          timer_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.loops_ready) begin
            chan_ready_reg <= NUM_CHANNELS'(1) << sel_reg;
            state_reg      <= DONE;
          end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_reg    <= 1'b1;
            last_grant_reg <= sel_reg;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DONE: begin
          last_grant_reg <= sel_reg;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.loops_start = start_reg;
  assign bus.loops_sel   = sel_reg;
  assign bus.chan_ready  = chan_ready_reg;
  assign bus.busy        = busy_reg;
  assign bus.pending     = pending_reg;
  assign bus.overrun     = overrun_reg;
  assign bus.timeout_err = timeout_reg;
endmodule

// File: tb/tb_tracking_arbiter.sv
// Directed bench for tracking_arbiter: drives and samples on the falling edge,
// one cycle per negedge, with hand-computed expectations.
module tb_tracking_arbiter;
  logic clk;
  logic global_reset;
  int   n_checks;
  int   n_fail;

  tracking_arbiter_if #(.NUM_CHANNELS(4), .SEL_WIDTH(2)) bus ();

  tracking_arbiter #(
    .NUM_CHANNELS(4),
    .SEL_WIDTH(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .global_reset(global_reset),
    .bus(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    global_reset    = 1'b1;
    bus.req_valid   = 4'b0000;
    bus.loops_ready = 1'b0;
    tick();
    tick();
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_sel", 32'(bus.loops_sel), 32'h0);
    chk("rst_start", 32'(bus.loops_start), 32'h0);
    chk("rst_chan_ready", 32'(bus.chan_ready), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'h0);
    global_reset = 1'b0;
  endtask

  // Wait (bounded) for loops_start, check the grant, answer after wait_cycles.
  task automatic grant_cycle(input int exp_ch, input int wait_cycles);
    int n;
    n = 0;
    while (bus.loops_start !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(bus.loops_start), 32'h1);
    chk("grant_sel", 32'(bus.loops_sel), 32'(exp_ch));
    repeat (wait_cycles) tick();
    bus.loops_ready = 1'b1;
    tick();
    bus.loops_ready = 1'b0;
    chk("chan_ready", 32'(bus.chan_ready), 32'(1) << exp_ch);
    chk("sel_held", 32'(bus.loops_sel), 32'(exp_ch));
    tick();
    chk("idle_after_done", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    logic [3:0] rr_pend [4];
    logic [3:0] cr_seen;
    logic       to_early;
    n_checks = 0;
    n_fail   = 0;
    rr_pend[0] = 4'b1110;
    rr_pend[1] = 4'b1100;
    rr_pend[2] = 4'b1000;
    rr_pend[3] = 4'b0000;

    do_reset();

    // Single request: start at cycle 2, loops_ready at 10, chan_ready at 11.
    bus.req_valid = 4'b0001;                       // cycle 0
    tick();
    bus.req_valid = 4'b0000;                       // cycle 1
    chk("single_pending", 32'(bus.pending), 32'h1);
    chk("single_busy_c1", 32'(bus.busy), 32'h0);
    chk("single_nostart_c1", 32'(bus.loops_start), 32'h0);
    tick();                                        // cycle 2
    chk("single_start_c2", 32'(bus.loops_start), 32'h1);
    chk("single_sel", 32'(bus.loops_sel), 32'h0);
    chk("single_busy_c2", 32'(bus.busy), 32'h1);
    repeat (8) tick();                             // cycle 10
    chk("single_busy_c10", 32'(bus.busy), 32'h1);
    chk("single_nocr_c10", 32'(bus.chan_ready), 32'h0);
    bus.loops_ready = 1'b1;
    tick();                                        // cycle 11
    bus.loops_ready = 1'b0;
    chk("single_cr_c11", 32'(bus.chan_ready), 32'h1);
    chk("single_busy_c11", 32'(bus.busy), 32'h1);
    tick();                                        // cycle 12
    chk("single_busy_c12", 32'(bus.busy), 32'h0);
    chk("single_cr_c12", 32'(bus.chan_ready), 32'h0);

    // Round-robin from reset: grants 0,1,2,3, loops_ready 5 cycles after start.
    do_reset();
    bus.req_valid = 4'b1111;
    tick();
    bus.req_valid = 4'b0000;
    chk("rr_pending_all", 32'(bus.pending), 32'hF);
    tick();
    for (int g = 0; g < 4; g++) begin
      chk("rr_start", 32'(bus.loops_start), 32'h1);
      chk("rr_sel", 32'(bus.loops_sel), 32'(g));
      tick();
      chk("rr_pending", 32'(bus.pending), 32'(rr_pend[g]));
      repeat (4) tick();
      bus.loops_ready = 1'b1;
      tick();
      bus.loops_ready = 1'b0;
      chk("rr_chan_ready", 32'(bus.chan_ready), 32'(1) << g);
      tick();
      chk("rr_idle", 32'(bus.busy), 32'h0);
      tick();
    end

    // Fairness: after channel 2, pending 0101 is served 0 then 2.
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b0000;
    grant_cycle(2, 3);
    bus.req_valid = 4'b0101;
    tick();
    bus.req_valid = 4'b0000;
    chk("fair_pending", 32'(bus.pending), 32'h5);
    grant_cycle(0, 3);
    grant_cycle(2, 3);
    chk("fair_drained", 32'(bus.pending), 32'h0);

    // Set-wins: request for channel 1 during its START re-queues it.
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    bus.req_valid = 4'b0010;
    chk("setwin_start", 32'(bus.loops_start), 32'h1);
    chk("setwin_sel", 32'(bus.loops_sel), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    chk("setwin_pending", 32'(bus.pending), 32'h2);
    chk("setwin_no_overrun", 32'(bus.overrun), 32'h0);
    tick();
    bus.loops_ready = 1'b1;
    tick();
    bus.loops_ready = 1'b0;
    chk("setwin_cr", 32'(bus.chan_ready), 32'h2);
    tick();
    grant_cycle(1, 3);
    chk("setwin_overrun_still0", 32'(bus.overrun), 32'h0);

    // Overrun: second request while pending[1] is already set.
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    chk("overrun_set", 32'(bus.overrun), 32'h1);
    grant_cycle(1, 3);
    chk("overrun_sticky", 32'(bus.overrun), 32'h1);
    chk("overrun_pending", 32'(bus.pending), 32'h0);

    // Timeout: channel 0 never answered, 16 WAIT cycles, then channel 1.
    bus.req_valid = 4'b0011;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("to_start", 32'(bus.loops_start), 32'h1);
    chk("to_sel", 32'(bus.loops_sel), 32'h0);
    cr_seen  = 4'b0000;
    to_early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cr_seen  = cr_seen | bus.chan_ready;
      to_early = to_early | bus.timeout_err;
    end
    chk("to_no_cr", 32'(cr_seen), 32'h0);
    chk("to_not_early", 32'(to_early), 32'h0);
    chk("to_busy_last_wait", 32'(bus.busy), 32'h1);
    tick();
    chk("to_flag", 32'(bus.timeout_err), 32'h1);
    chk("to_idle", 32'(bus.busy), 32'h0);
    chk("to_cr_zero", 32'(bus.chan_ready), 32'h0);
    chk("to_pending", 32'(bus.pending), 32'h2);
    grant_cycle(1, 3);
    chk("to_sticky", 32'(bus.timeout_err), 32'h1);

    // Reset in WAIT with pending 0110; request in reset cycle and late ready dropped.
    do_reset();
    bus.req_valid = 4'b0111;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("rw_sel", 32'(bus.loops_sel), 32'h0);
    tick();
    chk("rw_pending", 32'(bus.pending), 32'h6);
    tick();
    global_reset  = 1'b1;
    bus.req_valid = 4'b1000;
    tick();
    global_reset    = 1'b0;
    bus.req_valid   = 4'b0000;
    bus.loops_ready = 1'b1;
    chk("rw_pending_clr", 32'(bus.pending), 32'h0);
    chk("rw_busy", 32'(bus.busy), 32'h0);
    chk("rw_cr", 32'(bus.chan_ready), 32'h0);
    tick();
    bus.loops_ready = 1'b0;
    chk("late_ready_cr", 32'(bus.chan_ready), 32'h0);
    chk("late_ready_busy", 32'(bus.busy), 32'h0);
    chk("late_ready_start", 32'(bus.loops_start), 32'h0);
    chk("late_ready_pending", 32'(bus.pending), 32'h0);
    tick();
    chk("late_ready_still_idle", 32'(bus.busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
